axis_rr_arbiter: RTL and testbench

//  Packet-level round-robin arbiter. Shares the single AXI-Stream write port of the memory

---
 rtl/axis_rr_arbiter.sv | 75 +++++++
 tb/tb_axis_rr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter sharing one AXI-Stream port between N_REQ requesters
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 2,
    parameter int MAX_BEATS  = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [N_REQ*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [N_REQ*DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [N_REQ-1:0]              s_axis_tvalid,
    input  logic [N_REQ-1:0]              s_axis_tlast,
    output logic [N_REQ-1:0]              s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]       m_axis_tstrb,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          busy,
    output logic                          err_trunc
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BEATS + 1);
    typedef enum logic {IDLE, XFER} state_t;
    state_t        state_q;
    logic [GW-1:0] ptr_q, grant_q, pick, idx;
    logic [CW-1:0] cnt_q;
    logic          err_q, xfer, fwd, at_limit, accept;
    // Scan downward so the first valid requester at or above the pointer wins.
    always_comb begin
        pick = ptr_q;
        idx  = ptr_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(ptr_q) + k) % N_REQ);
            if (s_axis_tvalid[idx]) pick = idx;
        end
    end
    assign xfer          = state_q == XFER;
    assign fwd           = xfer & ~areset;
    assign at_limit      = cnt_q == CW'(MAX_BEATS - 1);
    assign m_axis_tvalid = fwd & s_axis_tvalid[grant_q];
    assign m_axis_tdata  = fwd ? s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_axis_tstrb  = fwd ? s_axis_tstrb[grant_q*SW +: SW] : '0;
    assign m_axis_tlast  = fwd & (s_axis_tlast[grant_q] | at_limit);
    assign s_axis_tready = (fwd & m_axis_tready) ? N_REQ'(1) << grant_q : '0;
    assign accept        = m_axis_tvalid & m_axis_tready;
    assign grant_id      = grant_q;
    assign busy          = xfer;
    assign err_trunc     = err_q;
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (!xfer) begin
            if (|s_axis_tvalid) begin
                state_q <= XFER;
                grant_q <= pick;
                cnt_q   <= '0;
            end
        end else if (accept) begin
            if (m_axis_tlast) begin
                state_q <= IDLE;
                ptr_q   <= (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                err_q   <= err_q | ~s_axis_tlast[grant_q];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed stimulus checked every cycle against a packet-level model plus literal beat logs
module tb_axis_rr_arbiter;
    localparam int DW = 32, N = 2, MAXB = 16, SW = DW / 8;
    logic            aclk = 1'b0, areset = 1'b1;
    logic [N*DW-1:0] s_axis_tdata;
    logic [N*SW-1:0] s_axis_tstrb;
    logic [N-1:0]    s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [SW-1:0]   m_axis_tstrb;
    logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [$clog2(N)-1:0] grant_id;
    logic            busy, err_trunc;

    always #5 aclk = ~aclk;

    axis_rr_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .MAX_BEATS(MAXB)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .grant_id(grant_id), .busy(busy), .err_trunc(err_trunc)
    );

    typedef struct { logic [DW-1:0] d; logic [SW-1:0] s; logic l; } beat_t;
    typedef struct { logic [DW-1:0] d; logic l; int g; int cyc; } obs_t;
    beat_t rq[N][$];
    logic  mt_q[$];
    obs_t  log_q[$];
    int    checks = 0, errors = 0, cyc = 0;
    bit    armed = 0;
    int    m_owner = -1, m_ptr = 0, m_gid = 0, m_cnt = 0;
    bit    m_err = 0;

    function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endfunction

    // Model: an owner index (-1 when idle), a rotation pointer and a beat count per packet.
    always @(negedge aclk) begin : compare
        int g, c;
        bit fwd;
        logic [N-1:0]  e_rdy;
        logic          e_v, e_l;
        logic [DW-1:0] e_d;
        logic [SW-1:0] e_s;
        cyc++;
        fwd   = m_owner >= 0 && !areset;
        g     = fwd ? m_owner : 0;
        e_v   = fwd && s_axis_tvalid[g];
        e_d   = fwd ? s_axis_tdata[g*DW +: DW] : '0;
        e_s   = fwd ? s_axis_tstrb[g*SW +: SW] : '0;
        e_l   = fwd && (s_axis_tlast[g] || m_cnt == MAXB - 1);
        e_rdy = '0;
        if (fwd && m_axis_tready) e_rdy[g] = 1'b1;
        if (armed) begin
            chk("m_tvalid", m_axis_tvalid, e_v);
            chk("m_tdata", m_axis_tdata, e_d);
            chk("m_tstrb", m_axis_tstrb, e_s);
            chk("m_tlast", m_axis_tlast, e_l);
            chk("s_tready", s_axis_tready, e_rdy);
            chk("grant_id", grant_id, m_gid);
            chk("busy", busy, m_owner >= 0);
            chk("err_trunc", err_trunc, m_err);
        end
        if (armed && !areset && m_axis_tvalid && m_axis_tready)
            log_q.push_back('{m_axis_tdata, m_axis_tlast, int'(grant_id), cyc});
        if (areset) begin
            m_owner = -1; m_ptr = 0; m_gid = 0; m_cnt = 0; m_err = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (m_owner < 0 && s_axis_tvalid[c]) m_owner = c;
            end
            if (m_owner >= 0) begin m_gid = m_owner; m_cnt = 0; end
        end else if (e_v && m_axis_tready) begin
            if (e_l) begin
                if (!s_axis_tlast[g]) m_err = 1;
                m_ptr = (g + 1) % N;
                m_owner = -1;
            end else m_cnt++;
        end
        if (areset) armed = 1;
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_axis_tvalid[i]          = rq[i].size() > 0;
            s_axis_tdata[i*DW +: DW]  = rq[i].size() > 0 ? rq[i][0].d : '0;
            s_axis_tstrb[i*SW +: SW]  = rq[i].size() > 0 ? rq[i][0].s : '0;
            s_axis_tlast[i]           = rq[i].size() > 0 ? rq[i][0].l : 1'b0;
        end
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        @(negedge aclk);
        acc = s_axis_tvalid & s_axis_tready;
        @(posedge aclk);
        #1;
        if (!areset)
            for (int i = 0; i < N; i++) if (acc[i]) void'(rq[i].pop_front());
        m_axis_tready = mt_q.size() > 0 ? mt_q.pop_front() : 1'b1;
        drive();
    endtask

    task automatic load(int r, int base, int n);
        for (int k = 0; k < n; k++)
            rq[r].push_back('{DW'(base + k), SW'((base + k) % 15 + 1), k == n - 1});
    endtask

    task automatic wait_log(int n, int budget, string nm);
        int b = 0;
        while (log_q.size() < n && b < budget) begin tick(); b++; end
        chk(nm, log_q.size(), n);
    endtask

    task automatic exp_beat(string t, int i, int d, logic l, int g);
        if (i < log_q.size()) begin
            chk($sformatf("%s_data%0d", t, i), log_q[i].d, d);
            chk($sformatf("%s_last%0d", t, i), log_q[i].l, l);
            chk($sformatf("%s_gid%0d", t, i), log_q[i].g, g);
        end else chk($sformatf("%s_count%0d", t, i), log_q.size(), i + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_axis_tready = 1'b1;
        s_axis_tvalid = '1; s_axis_tlast = '0; s_axis_tdata = '0; s_axis_tstrb = '0;
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_err", err_trunc, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        drive();
        // contention: pointer 0 serves req0 first, one bubble, then req1
        log_q.delete();
        load(0, 'hA0, 4);
        load(1, 'hB0, 4);
        drive();
        wait_log(8, 40, "t2_len");
        for (int i = 0; i < 4; i++) exp_beat("t2", i, 'hA0 + i, i == 3, 0);
        for (int i = 0; i < 4; i++) exp_beat("t2", 4 + i, 'hB0 + i, i == 3, 1);
        if (log_q.size() >= 5) chk("t2_bubble", log_q[4].cyc - log_q[3].cyc, 2);
        chk("t2_err", err_trunc, 0);
        repeat (2) tick();
        // fairness: req1 arrives while req0 streams and gets the next slot
        log_q.delete();
        load(0, 'hC0, 2); load(0, 'hC2, 2); load(0, 'hC4, 2);
        drive();
        repeat (2) tick();
        load(1, 'hD0, 2);
        wait_log(8, 60, "t3_len");
        exp_beat("t3", 0, 'hC0, 0, 0); exp_beat("t3", 1, 'hC1, 1, 0);
        exp_beat("t3", 2, 'hD0, 0, 1); exp_beat("t3", 3, 'hD1, 1, 1);
        exp_beat("t3", 4, 'hC2, 0, 0); exp_beat("t3", 5, 'hC3, 1, 0);
        exp_beat("t3", 6, 'hC4, 0, 0); exp_beat("t3", 7, 'hC5, 1, 0);
        repeat (2) tick();
        // backpressure with a waiting req0; pointer is 1 so req1 goes first
        log_q.delete();
        load(1, 'hE0, 3);
        load(0, 'hF0, 1);
        for (int i = 0; i < 10; i++) mt_q.push_back(i % 2 == 0);
        drive();
        wait_log(4, 40, "t4_len");
        repeat (4) tick();
        chk("t4_once", log_q.size(), 4);
        for (int i = 0; i < 3; i++) exp_beat("t4", i, 'hE0 + i, i == 2, 1);
        exp_beat("t4", 3, 'hF0, 1, 0);
        // truncation at MAX_BEATS, remainder re-arbitrated
        chk("t5_err_before", err_trunc, 0);
        log_q.delete();
        load(0, 'h100, 20);
        drive();
        wait_log(20, 80, "t5_len");
        for (int i = 0; i < 20; i++) exp_beat("t5", i, 'h100 + i, i == 15 || i == 19, 0);
        if (log_q.size() >= 17) chk("t5_bubble", log_q[16].cyc - log_q[15].cyc, 2);
        chk("t5_err_after", err_trunc, 1);
        repeat (2) tick();
        // reset on beat 2 of 4; pointer back to 0 so req0 wins the next tie
        log_q.delete();
        load(1, 'h200, 4);
        drive();
        wait_log(2, 20, "t6_pre");
        areset = 1'b1;
        tick();
        areset = 1'b0;
        rq[0].delete();
        rq[1].delete();
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant_id, 0);
        chk("t6_err", err_trunc, 0);
        load(0, 'h300, 2);
        load(1, 'h310, 1);
        drive();
        wait_log(5, 40, "t6_len");
        exp_beat("t6", 0, 'h200, 0, 1); exp_beat("t6", 1, 'h201, 0, 1);
        exp_beat("t6", 2, 'h300, 0, 0); exp_beat("t6", 3, 'h301, 1, 0);
        exp_beat("t6", 4, 'h310, 1, 1);
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
